// File: rtl/mem_datos_ls_pkg.sv
// Shared encodings for the load/store data memory and its dump sequencer.
package mem_datos_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'b00,
        DUMP_READ  = 2'b01,
        DUMP_VALID = 2'b10,
        DUMP_DONE  = 2'b11
    } dump_state_t;

    // Size 11 is never legal; halves need an even lane, words lane 0.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: access_legal = 1'b1;
            SIZE_HALF: access_legal = ~lane[0];
            SIZE_WORD: access_legal = (lane == 2'b00);
            default:   access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_datos_ls_if.sv
// Pipeline load/store port plus dump handshake of the MEM-stage data memory.
interface mem_datos_ls_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 6
) ();
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_datawrite;
    logic                  i_memread;
    logic                  i_memwrite;
    logic [1:0]            i_size;
    logic                  i_unsigned;
    logic [DATA_WIDTH-1:0] o_dataread;
    logic                  o_misaligned;
    logic                  i_dump_start;
    logic                  i_dump_ready;
    logic                  o_dump_valid;
    logic [DATA_WIDTH-1:0] o_dump_data;
    logic [IDX_W-1:0]      o_dump_addr;
    logic                  o_dump_busy;
    logic                  o_dump_done;

    modport slave (
        input  i_address, i_datawrite, i_memread, i_memwrite, i_size, i_unsigned,
        input  i_dump_start, i_dump_ready,
        output o_dataread, o_misaligned,
        output o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
    );

    modport master (
        output i_address, i_datawrite, i_memread, i_memwrite, i_size, i_unsigned,
        output i_dump_start, i_dump_ready,
        input  o_dataread, o_misaligned,
        input  o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/mem_datos_ls_dump_seq.sv
// Dump sequencer: walks every word out over valid/ready, two cycles minimum per beat.
module mem_dump_seq
    import mem_datos_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [IDX_W-1:0]      rd_idx,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [IDX_W-1:0]      addr,
    output logic                  busy,
    output logic                  done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dump_state_t      state;
    logic [IDX_W-1:0] cnt;

    assign rd_idx = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DUMP_IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DUMP_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DUMP_READ;
                    end
                end
                DUMP_READ: begin
                    data  <= rd_data;
                    addr  <= cnt;
                    valid <= 1'b1;
                    state <= DUMP_VALID;
                end
                DUMP_VALID: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (cnt == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DUMP_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= DUMP_READ;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= DUMP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_datos_ls.sv
// MEM-stage data memory with byte/half/word load-store sizing, registered reads,
// misalignment flagging and a streaming dump port for the debug unit.
module mem_datos_ls
    import mem_datos_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    mem_datos_ls_if.slave bus
);
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mem_datos_ls: DATA_WIDTH must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_datos_ls: DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  legal;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_val;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wr_lanes;
    logic                  wr_en;
    logic [IDX_W-1:0]      dump_idx;
    logic                  unused_addr_hi;

    assign idx            = bus.i_address[2 +: IDX_W];
    assign lane           = bus.i_address[1:0];
    assign unused_addr_hi = ^bus.i_address[ADDR_WIDTH-1:IDX_W+2];
    assign legal          = access_legal(bus.i_size, lane);
    assign rd_word        = mem[idx];
    assign shifted        = rd_word >> {lane, 3'b000};
    // The dump owns the array while busy; only pipeline stores are locked out.
    assign wr_en          = bus.i_memwrite & legal & ~bus.o_dump_busy;

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = '0;
        case (bus.i_size)
            SIZE_BYTE: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{bus.i_datawrite[7:0]}};
            end
            SIZE_HALF: begin
                byte_en  = 4'b0011 << lane;
                wr_lanes = {2{bus.i_datawrite[15:0]}};
            end
            SIZE_WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = bus.i_datawrite;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_val = '0;
        if (legal) begin
            case (bus.i_size)
                SIZE_BYTE: load_val = bus.i_unsigned ? {24'b0, shifted[7:0]}
                                                     : {{24{shifted[7]}}, shifted[7:0]};
                SIZE_HALF: load_val = bus.i_unsigned ? {16'b0, shifted[15:0]}
                                                     : {{16{shifted[15]}}, shifted[15:0]};
                SIZE_WORD: load_val = rd_word;
                default:   load_val = '0;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Array read above sees pre-edge contents, giving read-before-write.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bus.o_dataread   <= '0;
            bus.o_misaligned <= 1'b0;
        end else begin
            bus.o_misaligned <= (bus.i_memread | bus.i_memwrite) & ~legal;
            if (bus.i_memread) begin
                bus.o_dataread <= load_val;
            end
        end
    end

    mem_dump_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_dump (
        .clk     (i_clock),
        .rst     (i_reset),
        .start   (bus.i_dump_start),
        .ready   (bus.i_dump_ready),
        .rd_data (mem[dump_idx]),
        .rd_idx  (dump_idx),
        .valid   (bus.o_dump_valid),
        .data    (bus.o_dump_data),
        .addr    (bus.o_dump_addr),
        .busy    (bus.o_dump_busy),
        .done    (bus.o_dump_done)
    );

endmodule
